// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised next-PC selection and a
// circular return-address stack (RAS) for call/return prediction.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           hold pc and RAS (trap still takes effect)
//   trap            load TRAP_VECTOR and flush the RAS
//   ret             next pc from RAS top (falls back to pc_plus when empty)
//   branch_taken    next pc = branch_target
//   jump            next pc = jump_target; with call, push pc_plus
//   pc              registered fetch PC
//   pc_plus         pc + INC (wraps)
//   pc_next         selected next PC (combinational)
//   ras_count       number of valid RAS entries
//   ras_overflow    sticky flag: a push overwrote the oldest entry
//   ret_miss        one-cycle pulse after a ret with an empty RAS
module pc_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 'h80,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         trap,
  input  logic                         ret,
  input  logic                         branch_taken,
  input  logic [WIDTH-1:0]             branch_target,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jump_target,
  input  logic                         call,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus,
  output logic [WIDTH-1:0]             pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ret_miss
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic             advance;
  logic             push;
  logic             pop;

  // ras_ptr points at the next free slot; the top entry sits just below it.
  assign top_idx   = ras_ptr - PTR_W'(1);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign pc_plus   = pc + WIDTH'(INC);

  // A RAS update only happens on a cycle where the pc actually advances.
  assign advance = !stall && !trap;
  assign pop     = advance && ret && !ras_empty;
  // call only counts when jump is the winning source.
  assign push    = advance && !ret && !branch_taken && jump && call;

  always_comb begin
    pc_next = pc_plus;
    if (trap) begin
      pc_next = TRAP_VECTOR;
    end else if (ret) begin
      pc_next = ras_empty ? pc_plus : ras_mem[top_idx];
    end else if (branch_taken) begin
      pc_next = branch_target;
    end else if (jump) begin
      pc_next = jump_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      ras_ptr      <= '0;
      ras_count    <= '0;
      ras_overflow <= 1'b0;
      ret_miss     <= 1'b0;
    end else if (trap) begin
      // trap wins over stall and empties the stack
      pc        <= TRAP_VECTOR;
      ras_ptr   <= '0;
      ras_count <= '0;
      ret_miss  <= 1'b0;
    end else if (stall) begin
      ret_miss <= 1'b0;
    end else begin
      pc       <= pc_next;
      ret_miss <= ret && ras_empty;
      if (pop) begin
        ras_ptr   <= top_idx;
        ras_count <= ras_count - CNT_W'(1);
      end else if (push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_full) begin
          ras_overflow <= 1'b1;
        end else begin
          ras_count <= ras_count + CNT_W'(1);
        end
      end
    end
  end

  // Stack storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[ras_ptr] <= pc_plus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, trap, ret, branch_taken, jump, call;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus, pc_next;
  logic [2:0]  ras_count;
  logic        ras_overflow, ret_miss;

  int total = 0;
  int passed = 0;

  // reference model: pc plus a bounded LIFO that drops its oldest entry when full
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_ovf, m_miss;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .trap(trap), .ret(ret),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call),
    .pc(pc), .pc_plus(pc_plus), .pc_next(pc_next), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ret_miss(ret_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic st, input logic tr, input logic rt, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                       input logic cl);
    stall = st; trap = tr; ret = rt; branch_taken = br; branch_target = bt;
    jump = jp; jump_target = jt; call = cl;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_miss = 1'b0;
  endtask

  function automatic logic [31:0] model_next();
    if (trap) return 32'h80;
    if (ret) return (m_stack.size() > 0) ? m_stack[$] : m_pc + 32'd4;
    if (branch_taken) return branch_target;
    if (jump) return jump_target;
    return m_pc + 32'd4;
  endfunction

  // one clock: check combinational outputs, clock, update model, check registers
  task automatic cycle();
    logic [31:0] nx, pp;
    pp = m_pc + 32'd4;
    nx = model_next();
    #1;
    check("pc_plus", pc_plus, pp);
    check("pc_next", pc_next, nx);
    @(posedge clk);
    #1;
    if (trap) begin
      m_pc = 32'h80;
      m_stack.delete();
      m_miss = 1'b0;
    end else if (stall) begin
      m_miss = 1'b0;
    end else begin
      m_miss = ret && (m_stack.size() == 0);
      if (ret && m_stack.size() > 0) begin
        void'(m_stack.pop_back());
      end else if (!ret && !branch_taken && jump && call) begin
        if (m_stack.size() == 4) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(pp);
      end
      m_pc = nx;
    end
    check("pc", pc, m_pc);
    check("ras_count", {29'b0, ras_count}, 32'(m_stack.size()));
    check("ras_overflow", {31'b0, ras_overflow}, {31'b0, m_ovf});
    check("ret_miss", {31'b0, ret_miss}, {31'b0, m_miss});
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_count", {29'b0, ras_count}, 32'h0);
    check("reset_ovf", {31'b0, ras_overflow}, 32'h0);
    check("reset_miss", {31'b0, ret_miss}, 32'h0);
    rst = 1'b0;

    // sequential run 0,4,8,12,16
    repeat (4) idle();
    check("seq_pc16", pc, 32'h10);

    // call to 0x200, step, return to 0x14
    drive(0, 0, 0, 0, 32'h0, 1, 32'h200, 1);
    cycle();
    check("call_count", {29'b0, ras_count}, 32'd1);
    idle();
    check("at_204", pc, 32'h204);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    cycle();
    check("ret_pc", pc, 32'h14);
    check("ret_count", {29'b0, ras_count}, 32'd0);

    // ret on empty stack beats branch and jump
    drive(0, 0, 1, 1, 32'h40, 1, 32'h90, 0);
    cycle();
    check("miss_pc", pc, 32'h18);
    check("miss_pulse", {31'b0, ret_miss}, 32'd1);
    idle();
    check("miss_cleared", {31'b0, ret_miss}, 32'd0);

    // five nested calls overflow a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 32'h0, 1, 32'(i) << 12, 1);
      cycle();
    end
    check("nest_count", {29'b0, ras_count}, 32'd4);
    check("nest_ovf", {31'b0, ras_overflow}, 32'd1);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    cycle();
    check("nest_ret1", pc, 32'h4004);
    repeat (3) cycle();
    check("nest_ret4", pc, 32'h1004);
    cycle();
    check("nest_ret5_miss", {31'b0, ret_miss}, 32'd1);

    // stall holds even with jump pending; trap overrides stall
    drive(0, 0, 0, 0, 32'h0, 1, 32'h300, 1);
    cycle();
    drive(1, 0, 0, 0, 32'h0, 1, 32'h500, 1);
    repeat (3) cycle();
    check("stall_pc", pc, 32'h300);
    check("stall_count", {29'b0, ras_count}, 32'd1);
    drive(1, 1, 0, 0, 32'h0, 1, 32'h500, 0);
    cycle();
    check("trap_pc", pc, 32'h80);
    check("trap_count", {29'b0, ras_count}, 32'd0);

    // address wrap
    drive(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    cycle();
    idle();
    check("wrap_pc", pc, 32'h0);

    // asynchronous reset mid-run
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_ovf", {31'b0, ras_overflow}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 20) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) == 0,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
